// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline hazard controller for the 16-bit 5-stage core.
// It drives the stall and flush enables for the F/D, D/E and E/M pipeline registers.
// It resolves load-use and taken-branch hazards.
// It sequences multi-cycle mult/div operations that occupy the E stage.
// Optional feature macro: HAZARD_FORWARDING_EN.
//   Defined:   M/W results are forwarded into the E-stage operands.
//   Undefined: forwarding is off, and every D-stage read of an in-flight E/M destination stalls.
module hazard_sequencer #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES = 16,
  parameter logic [1:0] REGDATA_MEM = 2'b01,
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Da1,
  input  logic [3:0] Da2,
  input  logic [3:0] Ea1,
  input  logic [3:0] Ea2,
  input  logic [3:0] Ea3,
  input  logic       Ewe3,
  input  logic [1:0] Eregdata,
  input  logic       Ehilowrite,
  input  logic       Emultdiv,
  input  logic       Ebranch_taken,
  input  logic [3:0] Ma3,
  input  logic       Mwe3,
  input  logic [3:0] Wa3,
  input  logic       Wwe3,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic [1:0] forwardA,
  output logic [1:0] forwardB,
  output logic       md_busy,
  output logic       md_done
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  // Counter preload values: the start cycle and the DONE cycle are not counted.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 2);
  localparam logic MULT_SHORT = (MULT_CYCLES == 2);
  localparam logic DIV_SHORT  = (DIV_CYCLES == 2);

  md_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             start;
  logic             md_stall;
  logic             op_short;
  logic [CNT_W-1:0] op_load;
  logic             load_use;
  logic             data_hazard;

  assign start    = Ehilowrite & (state == IDLE);
  assign md_stall = start | (state == BUSY);
  assign op_short = Emultdiv ? DIV_SHORT : MULT_SHORT;
  assign op_load  = Emultdiv ? DIV_LOAD : MULT_LOAD;

  assign load_use = Ewe3 & (Eregdata == REGDATA_MEM) & ((Ea3 == Da1) | (Ea3 == Da2));

`ifdef HAZARD_FORWARDING_EN
  // With forwarding, only a load result arrives too late for the E stage to consume.
  assign data_hazard = load_use;
`else
  // Without forwarding, any D-stage read of an E or M destination must wait for write-back.
  assign data_hazard = load_use
                     | (Ewe3 & ((Ea3 == Da1) | (Ea3 == Da2)))
                     | (Mwe3 & ((Ma3 == Da1) | (Ma3 == Da2)));

  // W-stage and E-stage source addresses are only used by the forwarding muxes.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{Wa3, Wwe3, Ea1, Ea2};
`endif

  // Register the mult/div sequencer state and its down-counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Compute the next state: start -> (BUSY for N-2 cycles) -> DONE -> IDLE.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          if (op_short) begin
            state_next = DONE;
          end else begin
            state_next = BUSY;
            cnt_next   = op_load;
          end
        end
      end
      BUSY: begin
        if (cnt == CNT_W'(1)) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Decode pipeline controls: an md stall beats a branch flush, which beats a data hazard.
  always_comb begin
    stallF   = 1'b0;
    stallD   = 1'b0;
    stallE   = 1'b0;
    flushD   = 1'b0;
    flushE   = 1'b0;
    flushM   = 1'b0;
    forwardA = 2'b00;
    forwardB = 2'b00;
    md_busy  = 1'b0;
    md_done  = 1'b0;
    if (!reset) begin
      md_busy = start | (state != IDLE);
      md_done = (state == DONE);
      if (md_stall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        flushM = 1'b1;
      end else if (Ebranch_taken) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (data_hazard) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
`ifdef HAZARD_FORWARDING_EN
      if (Mwe3 && (Ma3 == Ea1))      forwardA = 2'b10;
      else if (Wwe3 && (Wa3 == Ea1)) forwardA = 2'b01;
      if (Mwe3 && (Ma3 == Ea2))      forwardB = 2'b10;
      else if (Wwe3 && (Wa3 == Ea2)) forwardB = 2'b01;
`endif
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: self-checking bench for hazard_sequencer.
// The bench applies directed scenarios followed by random traffic.
// A reference model tracks the remaining E-stage occupancy of a mult/div operation as a plain integer.
// When HAZARD_FORWARDING_EN is defined, the bench exercises the forwarding build.
module tb_hazard_sequencer;

  localparam int MULT_N = 4;
  localparam int DIV_N  = 16;

  typedef struct packed {
    logic       rst;
    logic [3:0] Da1;
    logic [3:0] Da2;
    logic [3:0] Ea1;
    logic [3:0] Ea2;
    logic [3:0] Ea3;
    logic       Ewe3;
    logic [1:0] Eregdata;
    logic       Ehilowrite;
    logic       Emultdiv;
    logic       Ebranch_taken;
    logic [3:0] Ma3;
    logic       Mwe3;
    logic [3:0] Wa3;
    logic       Wwe3;
  } stim_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Da1, Da2, Ea1, Ea2, Ea3, Ma3, Wa3;
  logic       Ewe3, Ehilowrite, Emultdiv, Ebranch_taken, Mwe3, Wwe3;
  logic [1:0] Eregdata;
  logic       stallF, stallD, stallE, flushD, flushE, flushM, md_busy, md_done;
  logic [1:0] forwardA, forwardB;

  int    checks = 0;
  int    errors = 0;
  int    mdLeft = 0;
  int    nextLeft = 0;
  stim_t cur;
  stim_t s;

  hazard_sequencer #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES(DIV_N),
    .REGDATA_MEM(2'b01),
    .CNT_W(5)
  ) dut (
    .clk(clk), .reset(reset),
    .Da1(Da1), .Da2(Da2), .Ea1(Ea1), .Ea2(Ea2), .Ea3(Ea3),
    .Ewe3(Ewe3), .Eregdata(Eregdata), .Ehilowrite(Ehilowrite), .Emultdiv(Emultdiv),
    .Ebranch_taken(Ebranch_taken), .Ma3(Ma3), .Mwe3(Mwe3), .Wa3(Wa3), .Wwe3(Wwe3),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .forwardA(forwardA), .forwardB(forwardB),
    .md_busy(md_busy), .md_done(md_done)
  );

  always #5 clk = ~clk;

  // Drive one cycle's worth of inputs and remember them for the model.
  task automatic applyStimulus(input stim_t st);
    cur           = st;
    reset         = st.rst;
    Da1           = st.Da1;
    Da2           = st.Da2;
    Ea1           = st.Ea1;
    Ea2           = st.Ea2;
    Ea3           = st.Ea3;
    Ewe3          = st.Ewe3;
    Eregdata      = st.Eregdata;
    Ehilowrite    = st.Ehilowrite;
    Emultdiv      = st.Emultdiv;
    Ebranch_taken = st.Ebranch_taken;
    Ma3           = st.Ma3;
    Mwe3          = st.Mwe3;
    Wa3           = st.Wa3;
    Wwe3          = st.Wwe3;
  endtask

  task automatic checkOne(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model for the currently applied inputs.
  task automatic checkOutput(input string step);
    int   eff;
    logic eStallF, eStallD, eStallE, eFlushD, eFlushE, eFlushM, eBusy, eDone;
    logic [1:0] eFa, eFb;
    logic srcE, srcM, hazard;
    #1;
    eStallF = 0; eStallD = 0; eStallE = 0; eFlushD = 0; eFlushE = 0; eFlushM = 0;
    eBusy = 0; eDone = 0; eFa = 2'b00; eFb = 2'b00;
    eff = (mdLeft == 0 && cur.Ehilowrite) ? (cur.Emultdiv ? DIV_N : MULT_N) : mdLeft;
    if (!cur.rst) begin
      eBusy  = (eff > 0);
      eDone  = (eff == 1);
      srcE   = (cur.Ea3 == cur.Da1) || (cur.Ea3 == cur.Da2);
      srcM   = (cur.Ma3 == cur.Da1) || (cur.Ma3 == cur.Da2);
      hazard = cur.Ewe3 && cur.Eregdata == 2'b01 && srcE;
`ifndef HAZARD_FORWARDING_EN
      hazard = hazard || (cur.Ewe3 && srcE) || (cur.Mwe3 && srcM);
`else
      eFa = (cur.Mwe3 && cur.Ma3 == cur.Ea1) ? 2'b10 : (cur.Wwe3 && cur.Wa3 == cur.Ea1) ? 2'b01 : 2'b00;
      eFb = (cur.Mwe3 && cur.Ma3 == cur.Ea2) ? 2'b10 : (cur.Wwe3 && cur.Wa3 == cur.Ea2) ? 2'b01 : 2'b00;
`endif
      if (eff > 1) begin
        eStallF = 1; eStallD = 1; eStallE = 1; eFlushM = 1;
      end else if (cur.Ebranch_taken) begin
        eFlushD = 1; eFlushE = 1;
      end else if (hazard) begin
        eStallF = 1; eStallD = 1; eFlushE = 1;
      end
    end
    checkOne({step, ".stallF"}, {1'b0, stallF}, {1'b0, eStallF});
    checkOne({step, ".stallD"}, {1'b0, stallD}, {1'b0, eStallD});
    checkOne({step, ".stallE"}, {1'b0, stallE}, {1'b0, eStallE});
    checkOne({step, ".flushD"}, {1'b0, flushD}, {1'b0, eFlushD});
    checkOne({step, ".flushE"}, {1'b0, flushE}, {1'b0, eFlushE});
    checkOne({step, ".flushM"}, {1'b0, flushM}, {1'b0, eFlushM});
    checkOne({step, ".md_busy"}, {1'b0, md_busy}, {1'b0, eBusy});
    checkOne({step, ".md_done"}, {1'b0, md_done}, {1'b0, eDone});
    checkOne({step, ".forwardA"}, forwardA, eFa);
    checkOne({step, ".forwardB"}, forwardB, eFb);
    nextLeft = cur.rst ? 0 : ((eff > 0) ? eff - 1 : 0);
  endtask

  task automatic advanceCycle();
    @(posedge clk);
    #1;
    mdLeft = nextLeft;
  endtask

  task automatic runStep(input stim_t st, input string step);
    applyStimulus(st);
    checkOutput(step);
    advanceCycle();
  endtask

  initial begin
    // Reset with active inputs: outputs must stay quiet.
    s = '0;
    s.rst = 1; s.Ehilowrite = 1; s.Ebranch_taken = 1; s.Ewe3 = 1; s.Eregdata = 2'b01;
    runStep(s, "reset0");
    runStep(s, "reset1");

    // Multiply: three stall cycles, md_done on the fourth, idle on the fifth.
    s = '0; s.Ehilowrite = 1; s.Emultdiv = 0;
    for (int i = 1; i <= 4; i++) begin
      s.Ebranch_taken = (i == 2);
      runStep(s, $sformatf("mult%0d", i));
    end
    s = '0;
    runStep(s, "mult5");

    // Divide interrupted by reset at cycle 7.
    s = '0; s.Ehilowrite = 1; s.Emultdiv = 1;
    for (int i = 1; i <= 6; i++) runStep(s, $sformatf("div%0d", i));
    s.rst = 1;
    runStep(s, "div7rst");
    s = '0;
    runStep(s, "div8");
    runStep(s, "div9");

    // Load-use hazard, followed by the same addresses without a load.
    s = '0; s.Ewe3 = 1; s.Eregdata = 2'b01; s.Ea3 = 4'd5; s.Da2 = 4'd5; s.Da1 = 4'd1;
    runStep(s, "lu");
    s.Eregdata = 2'b00;
    runStep(s, "lu_alu");

    // A branch and a load-use in the same cycle: the flush wins.
    s.Eregdata = 2'b01; s.Ebranch_taken = 1;
    runStep(s, "br_lu");

`ifdef HAZARD_FORWARDING_EN
    // Forwarding priority: M ahead of W; an unmatched operand reads the RF.
    s = '0; s.Ma3 = 4'd3; s.Wa3 = 4'd3; s.Ea1 = 4'd3; s.Mwe3 = 1; s.Wwe3 = 1; s.Ea2 = 4'd9;
    runStep(s, "fwd_m");
    s.Mwe3 = 0;
    runStep(s, "fwd_w");
`else
    // Without forwarding, an M-stage write to a D source stalls.
    s = '0; s.Mwe3 = 1; s.Ma3 = 4'd7; s.Da1 = 4'd7; s.Da2 = 4'd2; s.Ea1 = 4'd7;
    runStep(s, "raw_m");
`endif

    // Full divide with Ehilowrite held through DONE: no restart in DONE, restart afterwards.
    s = '0; s.Ehilowrite = 1; s.Emultdiv = 1;
    for (int i = 1; i <= DIV_N + 2; i++) runStep(s, $sformatf("divfull%0d", i));
    s = '0;
    for (int i = 0; i < 20; i++) runStep(s, "drain");

    // Random traffic over a narrow address range to provoke many matches.
    for (int i = 0; i < 800; i++) begin
      s.rst           = ($urandom_range(0, 63) == 0);
      s.Da1           = 4'($urandom_range(0, 3));
      s.Da2           = 4'($urandom_range(0, 3));
      s.Ea1           = 4'($urandom_range(0, 3));
      s.Ea2           = 4'($urandom_range(0, 3));
      s.Ea3           = 4'($urandom_range(0, 3));
      s.Ma3           = 4'($urandom_range(0, 3));
      s.Wa3           = 4'($urandom_range(0, 3));
      s.Ewe3          = 1'($urandom_range(0, 1));
      s.Mwe3          = 1'($urandom_range(0, 1));
      s.Wwe3          = 1'($urandom_range(0, 1));
      s.Eregdata      = 2'($urandom_range(0, 3));
      s.Ehilowrite    = ($urandom_range(0, 3) == 0);
      s.Emultdiv      = 1'($urandom_range(0, 1));
      s.Ebranch_taken = ($urandom_range(0, 3) == 0);
      runStep(s, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
